// File: rtl/cfu_wb_pkg.sv
// Shared types and bus widths for the CFU Wishbone RAM responder.
package cfu_wb_pkg;

    localparam int unsigned WB_ADR_W = 30;
    localparam int unsigned WB_DAT_W = 32;
    localparam int unsigned WB_SEL_W = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP, TURN} wb_resp_state_t;

endpackage

// File: rtl/cfu_wb_ram_responder_if.sv
// Wishbone-classic bus between the CFU initiator (master) and the RAM responder (slave).
interface cfu_wb_ram_responder_if;

    logic [cfu_wb_pkg::WB_ADR_W-1:0] cfu_ram_adr;
    logic [cfu_wb_pkg::WB_DAT_W-1:0] cfu_ram_dat_mosi;
    logic [cfu_wb_pkg::WB_SEL_W-1:0] cfu_ram_sel;
    logic                            cfu_ram_cyc;
    logic                            cfu_ram_stb;
    logic                            cfu_ram_we;
    logic [2:0]                      cfu_ram_cti;
    logic [1:0]                      cfu_ram_bte;
    logic [cfu_wb_pkg::WB_DAT_W-1:0] cfu_ram_dat_miso;
    logic                            cfu_ram_ack;
    logic                            cfu_ram_err;

    modport master (
        output cfu_ram_adr, cfu_ram_dat_mosi, cfu_ram_sel, cfu_ram_cyc, cfu_ram_stb,
               cfu_ram_we, cfu_ram_cti, cfu_ram_bte,
        input  cfu_ram_dat_miso, cfu_ram_ack, cfu_ram_err
    );

    modport slave (
        input  cfu_ram_adr, cfu_ram_dat_mosi, cfu_ram_sel, cfu_ram_cyc, cfu_ram_stb,
               cfu_ram_we, cfu_ram_cti, cfu_ram_bte,
        output cfu_ram_dat_miso, cfu_ram_ack, cfu_ram_err
    );

endinterface

// File: rtl/cfu_wb_byte_ram.sv
// Single-clock RAM: byte-enabled read/write port plus a full-word write port that wins collisions.
module cfu_wb_byte_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADR_W       = 10,
    parameter int unsigned INIT_ZERO   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_we,
    input  logic [ADR_W-1:0] i_adr,
    input  logic [3:0]       i_sel,
    input  logic [31:0]      i_wdat,
    output logic [31:0]      o_rdat,
    input  logic             i_ld_we,
    input  logic [ADR_W-1:0] i_ld_adr,
    input  logic [31:0]      i_ld_dat
);

    localparam logic [31:0] INIT_WORD = (INIT_ZERO != 0) ? 32'h0 : 32'hx;

    logic [31:0] r_mem [DEPTH_WORDS] = '{default: INIT_WORD};

    // Full-word write is issued last so it overrides a same-word byte write.
    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_sel[i]) r_mem[i_adr][8*i +: 8] <= i_wdat[8*i +: 8];
            end
        end
        if (i_ld_we) r_mem[i_ld_adr] <= i_ld_dat;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_rdat <= '0;
        end else if (i_en && !i_we) begin
            o_rdat <= r_mem[i_adr];
        end else begin
            o_rdat <= '0;
        end
    end

endmodule

// File: rtl/cfu_wb_ram_responder.sv
// Wishbone-classic RAM responder with programmable wait states, range checking and a preload port.
module cfu_wb_ram_responder
    import cfu_wb_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned INIT_ZERO   = 0
) (
    input  logic                clk,
    input  logic                reset,
    cfu_wb_ram_responder_if.slave bus,
    input  logic                load_we,
    input  logic [WB_ADR_W-1:0] load_adr,
    input  logic [WB_DAT_W-1:0] load_dat,
    output logic [31:0]         xfer_count
);

    localparam int unsigned RAM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    wb_resp_state_t      r_state, w_state_d;
    logic [3:0]          r_cnt, w_cnt_d;
    logic                w_capture;
    logic [WB_ADR_W-1:0] r_adr;
    logic                r_we;
    logic [WB_SEL_W-1:0] r_sel;
    logic [WB_DAT_W-1:0] r_dat;
    logic                r_ack, r_err;
    logic [31:0]         r_xfer;
    logic                w_in_range, w_resp, w_ld_ok;
    logic [WB_DAT_W-1:0] w_rdat;
    logic                w_unused;

    assign w_unused   = ^{bus.cfu_ram_cti, bus.cfu_ram_bte};
    assign w_in_range = {2'b00, r_adr} < DEPTH_WORDS;
    assign w_resp     = (r_state == RESP);
    assign w_ld_ok    = load_we && ({2'b00, load_adr} < DEPTH_WORDS);

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_capture = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.cfu_ram_cyc && bus.cfu_ram_stb) begin
                    w_capture = 1'b1;
                    if (WAIT_STATES == 0) begin
                        w_state_d = RESP;
                    end else begin
                        w_cnt_d   = 4'(WAIT_STATES - 1);
                        w_state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // Losing cyc cancels; stb alone is irrelevant once the request is latched.
                if (!bus.cfu_ram_cyc) begin
                    w_state_d = IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_state_d = RESP;
                end else begin
                    w_cnt_d = r_cnt - 4'd1;
                end
            end
            RESP:    w_state_d = TURN;
            TURN:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_adr   <= '0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_dat   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_xfer  <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (w_capture) begin
                r_adr <= bus.cfu_ram_adr;
                r_we  <= bus.cfu_ram_we;
                r_sel <= bus.cfu_ram_sel;
                r_dat <= bus.cfu_ram_dat_mosi;
            end
            r_ack <= w_resp && w_in_range;
            r_err <= w_resp && !w_in_range;
            if (w_resp && w_in_range) r_xfer <= r_xfer + 32'd1;
        end
    end

    cfu_wb_byte_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADR_W       (RAM_AW),
        .INIT_ZERO   (INIT_ZERO)
    ) u_ram (
        .clk      (clk),
        .reset    (reset),
        .i_en     (w_resp && w_in_range),
        .i_we     (r_we),
        .i_adr    (r_adr[RAM_AW-1:0]),
        .i_sel    (r_sel),
        .i_wdat   (r_dat),
        .o_rdat   (w_rdat),
        .i_ld_we  (w_ld_ok),
        .i_ld_adr (load_adr[RAM_AW-1:0]),
        .i_ld_dat (load_dat)
    );

    assign bus.cfu_ram_ack      = r_ack;
    assign bus.cfu_ram_err      = r_err;
    assign bus.cfu_ram_dat_miso = w_rdat;
    assign xfer_count           = r_xfer;

endmodule

// File: tb/tb_cfu_wb_ram_responder.sv
// Directed self-checking bench for cfu_wb_ram_responder (DEPTH_WORDS=1024, WAIT_STATES=2).
module tb_cfu_wb_ram_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_we = 1'b0;
    logic [29:0] load_adr = '0;
    logic [31:0] load_dat = '0;
    logic [31:0] xfer_count;
    int          n_cmp = 0;
    int          n_fail = 0;

    cfu_wb_ram_responder_if u_bus ();

    cfu_wb_ram_responder #(
        .DEPTH_WORDS (1024),
        .WAIT_STATES (2),
        .INIT_ZERO   (1)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (u_bus),
        .load_we    (load_we),
        .load_adr   (load_adr),
        .load_dat   (load_dat),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at a negedge.
    task automatic do_load(input logic [29:0] adr, input logic [31:0] dat);
        load_we = 1'b1; load_adr = adr; load_dat = dat;
        @(negedge clk);
        load_we = 1'b0;
    endtask

    // Single transfer, cyc/stb dropped once ack or err is seen (or after 20 cycles).
    task automatic bus_xfer(input logic [29:0] adr, input logic we, input logic [3:0] sel,
                            input logic [31:0] dat, output logic ack, output logic err,
                            output logic [31:0] rdat, output int edges);
        ack = 1'b0; err = 1'b0; rdat = '0; edges = 0;
        u_bus.cfu_ram_adr = adr; u_bus.cfu_ram_we = we; u_bus.cfu_ram_sel = sel;
        u_bus.cfu_ram_dat_mosi = dat; u_bus.cfu_ram_cyc = 1'b1; u_bus.cfu_ram_stb = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (u_bus.cfu_ram_ack || u_bus.cfu_ram_err) begin
                ack = u_bus.cfu_ram_ack; err = u_bus.cfu_ram_err; rdat = u_bus.cfu_ram_dat_miso;
                break;
            end
        end
        u_bus.cfu_ram_cyc = 1'b0; u_bus.cfu_ram_stb = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (u_bus.cfu_ram_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", u_bus.cfu_ram_ack); end
        n_cmp++; if (u_bus.cfu_ram_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", u_bus.cfu_ram_err); end
        n_cmp++; if (u_bus.cfu_ram_dat_miso !== 32'h0) begin n_fail++; $display("FAIL reset_miso: got %h want 0", u_bus.cfu_ram_dat_miso); end
        n_cmp++; if (xfer_count !== 32'h0) begin n_fail++; $display("FAIL reset_xfer: got %0d want 0", xfer_count); end
    endtask

    task automatic test_preload_read();
        logic ack, err; logic [31:0] d; int e;
        do_load(30'd5, 32'hDEADBEEF);
        do_load(30'd1029, 32'h0BADF00D);  // out of range: must be dropped, not aliased to 5
        bus_xfer(30'd5, 1'b0, 4'hF, 32'h0, ack, err, d, e);
        n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rd5_ack: got %b want 1", ack); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rd5_err: got %b want 0", err); end
        n_cmp++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd5_data: got %h want deadbeef", d); end
        n_cmp++; if (e !== 4) begin n_fail++; $display("FAIL rd5_latency: got %0d edges want 4", e); end
        n_cmp++; if (xfer_count !== 32'd1) begin n_fail++; $display("FAIL rd5_xfer: got %0d want 1", xfer_count); end
        @(negedge clk);
        n_cmp++; if (u_bus.cfu_ram_ack !== 1'b0) begin n_fail++; $display("FAIL rd5_ack_width: got %b want 0", u_bus.cfu_ram_ack); end
        n_cmp++; if (u_bus.cfu_ram_dat_miso !== 32'h0) begin n_fail++; $display("FAIL rd5_miso_idle: got %h want 0", u_bus.cfu_ram_dat_miso); end
    endtask

    task automatic test_byte_write();
        logic ack, err; logic [31:0] d; int e;
        do_load(30'd7, 32'h11223344);
        bus_xfer(30'd7, 1'b1, 4'b0101, 32'hAABBCCDD, ack, err, d, e);
        n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL wr7_ack: got %b want 1", ack); end
        n_cmp++; if (xfer_count !== 32'd2) begin n_fail++; $display("FAIL wr7_xfer: got %0d want 2", xfer_count); end
        @(negedge clk);
        bus_xfer(30'd7, 1'b0, 4'hF, 32'h0, ack, err, d, e);
        n_cmp++; if (d !== 32'h11BB33DD) begin n_fail++; $display("FAIL rd7_data: got %h want 11bb33dd", d); end
        n_cmp++; if (xfer_count !== 32'd3) begin n_fail++; $display("FAIL rd7_xfer: got %0d want 3", xfer_count); end
        @(negedge clk);
    endtask

    task automatic test_out_of_range();
        logic ack, err; logic [31:0] d; int e;
        bus_xfer(30'd1024, 1'b0, 4'hF, 32'h0, ack, err, d, e);
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL oor_err: got %b want 1", err); end
        n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL oor_ack: got %b want 0", ack); end
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL oor_miso: got %h want 0", d); end
        n_cmp++; if (xfer_count !== 32'd3) begin n_fail++; $display("FAIL oor_xfer: got %0d want 3", xfer_count); end
        @(negedge clk);
        n_cmp++; if (u_bus.cfu_ram_err !== 1'b0) begin n_fail++; $display("FAIL oor_err_width: got %b want 0", u_bus.cfu_ram_err); end
    endtask

    task automatic test_back_to_back();
        int n_ack = 0; int t0 = 0; int t1 = 0; logic [31:0] d0 = '0; logic [31:0] d1 = '0;
        do_load(30'd6, 32'hCAFEF00D);
        u_bus.cfu_ram_adr = 30'd5; u_bus.cfu_ram_we = 1'b0; u_bus.cfu_ram_sel = 4'hF;
        u_bus.cfu_ram_cyc = 1'b1; u_bus.cfu_ram_stb = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (u_bus.cfu_ram_ack) begin
                if (n_ack == 0) begin t0 = c; d0 = u_bus.cfu_ram_dat_miso; u_bus.cfu_ram_adr = 30'd6; end
                else if (n_ack == 1) begin
                    t1 = c; d1 = u_bus.cfu_ram_dat_miso;
                    u_bus.cfu_ram_cyc = 1'b0; u_bus.cfu_ram_stb = 1'b0;
                end
                n_ack++;
            end
        end
        u_bus.cfu_ram_cyc = 1'b0; u_bus.cfu_ram_stb = 1'b0;
        n_cmp++; if (n_ack !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", n_ack); end
        n_cmp++; if (t0 !== 4) begin n_fail++; $display("FAIL b2b_first: got cycle %0d want 4", t0); end
        n_cmp++; if (t1 - t0 !== 5) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 5", t1 - t0); end
        n_cmp++; if (d0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_data0: got %h want deadbeef", d0); end
        n_cmp++; if (d1 !== 32'hCAFEF00D) begin n_fail++; $display("FAIL b2b_data1: got %h want cafef00d", d1); end
        n_cmp++; if (xfer_count !== 32'd5) begin n_fail++; $display("FAIL b2b_xfer: got %0d want 5", xfer_count); end
    endtask

    task automatic test_abort();
        logic ack, err; logic [31:0] d; int e; int seen = 0;
        u_bus.cfu_ram_adr = 30'd5; u_bus.cfu_ram_we = 1'b1; u_bus.cfu_ram_sel = 4'hF;
        u_bus.cfu_ram_dat_mosi = 32'h12345678; u_bus.cfu_ram_cyc = 1'b1; u_bus.cfu_ram_stb = 1'b1;
        @(negedge clk);
        u_bus.cfu_ram_cyc = 1'b0; u_bus.cfu_ram_stb = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (u_bus.cfu_ram_ack || u_bus.cfu_ram_err) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL abort_resp: got %0d pulses want 0", seen); end
        n_cmp++; if (xfer_count !== 32'd5) begin n_fail++; $display("FAIL abort_xfer: got %0d want 5", xfer_count); end
        bus_xfer(30'd5, 1'b0, 4'hF, 32'h0, ack, err, d, e);
        n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL post_abort_ack: got %b want 1", ack); end
        n_cmp++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL post_abort_data: got %h want deadbeef", d); end
        n_cmp++; if (xfer_count !== 32'd6) begin n_fail++; $display("FAIL post_abort_xfer: got %0d want 6", xfer_count); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic ack, err; logic [31:0] d; int e; int seen = 0;
        u_bus.cfu_ram_adr = 30'd5; u_bus.cfu_ram_we = 1'b0; u_bus.cfu_ram_sel = 4'hF;
        u_bus.cfu_ram_cyc = 1'b1; u_bus.cfu_ram_stb = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        u_bus.cfu_ram_cyc = 1'b0; u_bus.cfu_ram_stb = 1'b0;
        #1;
        n_cmp++; if (u_bus.cfu_ram_ack !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ack: got %b want 0", u_bus.cfu_ram_ack); end
        n_cmp++; if (u_bus.cfu_ram_err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_err: got %b want 0", u_bus.cfu_ram_err); end
        n_cmp++; if (u_bus.cfu_ram_dat_miso !== 32'h0) begin n_fail++; $display("FAIL rst_mid_miso: got %h want 0", u_bus.cfu_ram_dat_miso); end
        n_cmp++; if (xfer_count !== 32'd0) begin n_fail++; $display("FAIL rst_mid_xfer: got %0d want 0", xfer_count); end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (u_bus.cfu_ram_ack || u_bus.cfu_ram_err) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL rst_mid_discard: got %0d pulses want 0", seen); end
        bus_xfer(30'd5, 1'b0, 4'hF, 32'h0, ack, err, d, e);
        n_cmp++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rst_mem_kept: got %h want deadbeef", d); end
        n_cmp++; if (e !== 4) begin n_fail++; $display("FAIL rst_idle_latency: got %0d edges want 4", e); end
        n_cmp++; if (xfer_count !== 32'd1) begin n_fail++; $display("FAIL rst_xfer_restart: got %0d want 1", xfer_count); end
    endtask

    initial begin
        u_bus.cfu_ram_adr = '0; u_bus.cfu_ram_dat_mosi = '0; u_bus.cfu_ram_sel = '0;
        u_bus.cfu_ram_cyc = 1'b0; u_bus.cfu_ram_stb = 1'b0; u_bus.cfu_ram_we = 1'b0;
        u_bus.cfu_ram_cti = 3'b000; u_bus.cfu_ram_bte = 2'b00;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_preload_read();
        test_byte_write();
        test_out_of_range();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
